pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter owner for the single-cycle core. It consumes the 2-bit pc_sel produced by the top-level PC-select logic, together with the branch offset and jump index from the datapath. It holds the architectural PC register, applies stall/halt control, and flags illegal or misaligned next-PC requests. It sits between the PC-select logic and the instruction-memory address port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 32, width of the retired-instruction counter and the optional stats counters.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
pc_sel  input  2  00 sequential, 01 branch taken, 10 jump, 11 reserved.
branch_offset  input  32  sign-extended byte offset, already shifted left by 2 upstream.
jump_index  input  26  jump instruction index field.
stall  input  1  hold PC and counters this cycle.
halt  input  1  request stop (e.g. halt opcode decoded).
pc  output  32  current fetch address.
pc_plus4  output  32  pc + 4, combinational.
fetch_valid  output  1  pc is a valid fetch address this cycle.
err_code  output  2  00 none, 01 misaligned target, 10 illegal pc_sel; sticky.
instr_count  output  CNT_W  retired (PC-advanced) instruction count.
taken_count  output  CNT_W  taken branches (optional feature).
jump_count  output  CNT_W  jumps (optional feature).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - pc=RESET_PC, state=BOOT, fetch_valid=0, err_code=00, instr_count=0, taken_count=0, jump_count=0.
- States: BOOT, RUN, HALT. Encoding comes from the shared header. fetch_valid is registered and is 1 only in RUN.
- BOOT: exactly one cycle, then goes to RUN unconditionally. pc stays at RESET_PC. First fetch_valid=1 is in the cycle after reset deassertion plus one edge.
- RUN, per edge, priority is halt > stall > error check > update.
  - halt=1: go to HALT, pc holds, no counter changes, no error recorded (even if the same cycle's pc_sel is illegal).
  - stall=1: everything holds; pc_sel is ignored.
  - Otherwise compute target:
    - 00: pc+4.
    - 01: pc+4+branch_offset, 32-bit modular.
    - 10: {pc_plus4[31:28], jump_index, 2'b00}.
    - 11: illegal.
  - Illegal pc_sel: err_code=10, go to HALT, pc holds.
  - Target[1:0]!=0 (only possible for 01): err_code=01, go to HALT, pc holds.
  - Else: pc<=target, instr_count+=1.
- HALT: fetch_valid=0; pc, counters and err_code frozen. Exit only via reset.
- Wrap-around rules:
  - pc+4 from 32'hFFFF_FFFC gives 0 with no error.
  - Branch arithmetic wraps modulo 2^32 with no error.
  - Counters wrap to 0 after all-ones.
- Latency: pc_sel and operands are sampled in the same cycle as the pc they relate to; the new pc is visible after 1 edge.

Optional Feature:
PC_BRANCH_STATS_EN
- Defined: taken_count increments on each committed 01 update; jump_count increments on each committed 10 update. Both follow the same stall/halt/error gating as instr_count.
- Undefined: both ports are present but tied to 0; no counter flops are synthesized.

Decomposition:
- Shared header pc_defs.vh holds:
  - PC_SEL_SEQ/BRANCH/JUMP/RSVD codes, matching the top-level select logic.
  - State encodings ST_BOOT/ST_RUN/ST_HALT.
  - ERR_NONE/ERR_MISALIGN/ERR_ILLEGAL_SEL.
- One combinational sub-module, pc_next_calc. Inputs: pc, pc_sel, branch_offset, jump_index. Outputs: target, misalign, illegal. The FSM, PC register and counters stay in pc_sequencer.

Test Plan:
1. Reset, then pc_sel=00 for 3 cycles after BOOT -> pc 0,0,4,8,C; fetch_valid 0 in BOOT then 1; instr_count=3.
2. pc=0x100, pc_sel=01, offset=0xFFFF_FFF0 -> pc=0xF4, taken_count=1 (feature on) or 0 (feature off).
3. pc=0x1000_0040, pc_sel=10, jump_index=26'h0000_100 -> pc=0x1000_0400, jump_count=1.
4. pc_sel=01, offset=0x2 -> err_code=01, state HALT, pc unchanged, fetch_valid=0. Then 3 more cycles of pc_sel=00 -> no change.
5. stall=1 with pc_sel=11 for 2 cycles -> no change, err_code=00. Then halt=1 with pc_sel=11 -> HALT with err_code=00.
6. Assert reset mid-RUN at pc=0x40 and between clock edges -> pc=RESET_PC immediately, counters=0. pc=0xFFFF_FFFC with pc_sel=00 -> pc=0, err_code=00.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared PC-select codes, state encodings and error codes
package pc_sequencer_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_e;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN    = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL_SEL = 2'b10;

endpackage

// File: rtl/pc_sequencer_next_calc.sv
// rtl/pc_sequencer_next_calc.sv - combinational next-PC target with misalign/illegal flags
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_index,
    output logic [31:0] target,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + 32'd4;

    always_comb begin
        target   = seq_pc;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (pc_sel)
            PC_SEL_SEQ:    target = seq_pc;
            PC_SEL_BRANCH: begin
                target   = seq_pc + branch_offset;
                // only a branch can land off a word boundary; sequential and jump targets are aligned by construction
                misalign = (target[1:0] != 2'b00);
            end
            PC_SEL_JUMP:   target = {seq_pc[31:28], jump_index, 2'b00};
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, BOOT/RUN/HALT control and retire counters; stats under PC_BRANCH_STATS_EN
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      branch_offset,
    input  logic [25:0]      jump_index,
    input  logic             stall,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] jump_count
);

    pc_state_e   state, state_next;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic [1:0]  err_next;
    logic        misalign;
    logic        illegal;
    logic        commit;

    assign pc_plus4 = pc + 32'd4;

    pc_next_calc u_next_calc (
        .pc            (pc),
        .pc_sel        (pc_sel),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .target        (target),
        .misalign      (misalign),
        .illegal       (illegal)
    );

    always_comb begin
        state_next = state;
        pc_next    = pc;
        err_next   = err_code;
        commit     = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                // halt wins over everything, so a halt alongside a bad pc_sel leaves err_code clean
                if (halt) begin
                    state_next = ST_HALT;
                end else if (!stall) begin
                    if (illegal) begin
                        err_next   = ERR_ILLEGAL_SEL;
                        state_next = ST_HALT;
                    end else if (misalign) begin
                        err_next   = ERR_MISALIGN;
                        state_next = ST_HALT;
                    end else begin
                        pc_next = target;
                        commit  = 1'b1;
                    end
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            err_code    <= ERR_NONE;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fetch_valid <= (state_next == ST_RUN);
            err_code    <= err_next;
            if (commit) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_count <= '0;
            jump_count  <= '0;
        end else if (commit) begin
            if (pc_sel == PC_SEL_BRANCH) begin
                taken_count <= taken_count + CNT_W'(1);
            end
            if (pc_sel == PC_SEL_JUMP) begin
                jump_count <= jump_count + CNT_W'(1);
            end
        end
    end
`else
    assign taken_count = '0;
    assign jump_count  = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

`ifdef PC_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  pc_sel;
    logic [31:0] branch_offset;
    logic [25:0] jump_index;
    logic        stall;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [1:0]  err_code;
    logic [31:0] instr_count;
    logic [31:0] taken_count;
    logic [31:0] jump_count;

    int vectors;
    int miscompares;

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_sel        (pc_sel),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .stall         (stall),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .err_code      (err_code),
        .instr_count   (instr_count),
        .taken_count   (taken_count),
        .jump_count    (jump_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        pc_sel        = 2'b00;
        branch_offset = 32'd0;
        jump_index    = 26'd0;
        stall         = 1'b0;
        halt          = 1'b0;

        repeat (2) step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_instr", instr_count, 32'd0);
        chk("rst_taken", taken_count, 32'd0);
        chk("rst_jump", jump_count, 32'd0);

        reset = 1'b0;
        #1;
        chk("boot_fv", 32'(fetch_valid), 32'd0);
        step();
        chk("run_pc0", pc, 32'h0);
        chk("run_fv", 32'(fetch_valid), 32'd1);
        step(); chk("seq_pc4", pc, 32'h4);
        step(); chk("seq_pc8", pc, 32'h8);
        step(); chk("seq_pcC", pc, 32'hC);
        chk("seq_instr", instr_count, 32'd3);

        pc_sel = 2'b10; jump_index = 26'h40;
        step();
        chk("j1_pc", pc, 32'h100);
        chk("j1_cnt", jump_count, st(1));
        chk("j1_instr", instr_count, 32'd4);

        pc_sel = 2'b01; branch_offset = 32'hFFFF_FFF0;
        step();
        chk("br_back_pc", pc, 32'hF4);
        chk("br_back_taken", taken_count, st(1));

        branch_offset = 32'h0FFF_FF48;
        step();
        chk("br_fwd_pc", pc, 32'h1000_0040);
        chk("pc_plus4", pc_plus4, 32'h1000_0044);

        pc_sel = 2'b10; jump_index = 26'h100;
        step();
        chk("j2_pc", pc, 32'h1000_0400);
        chk("j2_cnt", jump_count, st(2));
        chk("j2_instr", instr_count, 32'd7);

        pc_sel = 2'b01; branch_offset = 32'hEFFF_FBF8;
        step();
        chk("br_top_pc", pc, 32'hFFFF_FFFC);
        chk("br_top_taken", taken_count, st(3));
        chk("pc_plus4_wrap", pc_plus4, 32'h0);

        pc_sel = 2'b00;
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_err", 32'(err_code), 32'd0);
        chk("wrap_instr", instr_count, 32'd9);

        stall = 1'b1; pc_sel = 2'b11;
        repeat (2) step();
        chk("stall_pc", pc, 32'h0);
        chk("stall_err", 32'(err_code), 32'd0);
        chk("stall_fv", 32'(fetch_valid), 32'd1);
        chk("stall_instr", instr_count, 32'd9);

        stall = 1'b0; pc_sel = 2'b01; branch_offset = 32'h2;
        step();
        chk("mis_err", 32'(err_code), 32'd1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_fv", 32'(fetch_valid), 32'd0);
        chk("mis_taken", taken_count, st(3));

        pc_sel = 2'b00;
        repeat (3) step();
        chk("halt_pc", pc, 32'h0);
        chk("halt_instr", instr_count, 32'd9);
        chk("halt_err", 32'(err_code), 32'd1);
        chk("halt_fv", 32'(fetch_valid), 32'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pc_sel = 2'b10; jump_index = 26'h10;
        step();
        chk("pre_rst_pc", pc, 32'h40);
        chk("pre_rst_instr", instr_count, 32'd1);
        pc_sel = 2'b00;
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_instr", instr_count, 32'd0);
        chk("async_jump", jump_count, 32'd0);
        chk("async_fv", 32'(fetch_valid), 32'd0);
        chk("async_err", 32'(err_code), 32'd0);

        step();
        reset = 1'b0;
        step();
        chk("reboot_fv", 32'(fetch_valid), 32'd1);
        step();
        chk("reboot_pc", pc, 32'h4);

        halt = 1'b1; pc_sel = 2'b11;
        step();
        chk("hreq_fv", 32'(fetch_valid), 32'd0);
        chk("hreq_err", 32'(err_code), 32'd0);
        chk("hreq_pc", pc, 32'h4);
        halt = 1'b0;
        step();
        chk("hreq_err_frozen", 32'(err_code), 32'd0);
        chk("hreq_instr", instr_count, 32'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pc_sel = 2'b11;
        step();
        chk("ill_err", 32'(err_code), 32'd2);
        chk("ill_fv", 32'(fetch_valid), 32'd0);
        chk("ill_pc", pc, 32'h0);
        chk("ill_instr", instr_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
